// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V main control FSM.
// Contents:
//   - opcode constants for the supported instruction subset
//   - ALUOp encodings and the subtract FuncCode
//   - ALU source A/B and result mux encodings
//   - FSM state enum (13 states)
//   - instruction class enum produced by the opcode decoder
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_ITYPE = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ERR   = 2'b11;

    localparam logic [9:0] FUNC_SUB = 10'b0100000000;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMREAD,
        ST_MEMWB,
        ST_MEMWRITE,
        ST_EXECR,
        ST_EXECI,
        ST_ALUWB,
        ST_BEQ,
        ST_JAL,
        ST_LUI,
        ST_ERROR
    } state_t;

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_BEQ,
        CLS_JAL,
        CLS_LUI,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/riscv_opcode_dec.sv
// Combinational opcode classifier for the main control FSM.
// Ports:
//   opcode      in   IR[6:0]
//   funct3      in   IR[14:12] (only BEQ is a legal branch)
//   instr_class out  instruction class used by the DECODE/MEMADR transitions
//   illegal     out  high when the instruction is outside the supported subset
module riscv_opcode_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    output instr_class_t instr_class,
    output logic         illegal
);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        case (opcode)
            OP_LOAD:   instr_class = CLS_LOAD;
            OP_STORE:  instr_class = CLS_STORE;
            OP_RTYPE:  instr_class = CLS_RTYPE;
            OP_ITYPE:  instr_class = CLS_ITYPE;
            OP_BRANCH: instr_class = (funct3 == F3_BEQ) ? CLS_BEQ : CLS_ILLEGAL;
            OP_JAL:    instr_class = CLS_JAL;
            OP_LUI:    instr_class = CLS_LUI;
            default:   instr_class = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (instr_class == CLS_ILLEGAL);

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multicycle main control FSM for the RISC-V datapath.
// Fetches, decodes and steps each instruction through execute, memory and
// writeback states, driving the ALU decoder inputs, mux selects and write
// enables. Also keeps a wrapping count of retired instructions.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode/funct3/funct7 instruction register fields
//   zero                ALU zero flag (same cycle, used by BEQ)
//   mem_ready           memory completes the current access this cycle
//   alu_op, func_code   ALU control decoder inputs
//   alu_src_a/b, result_src, adr_src  datapath mux selects
//   pc_write, ir_write, mem_write, reg_write  write enables
//   illegal             sticky illegal-instruction flag
//   retired             retired-instruction count (CNT_W bits, wraps)
module riscv_mc_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic [9:0]       func_code,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic             adr_src,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_write,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_reg;
    state_t           state_next;
    logic             illegal_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             retire_now;

    instr_class_t     instr_class;
    logic             dec_illegal;

    riscv_opcode_dec u_dec (
        .opcode      (opcode),
        .funct3      (funct3),
        .instr_class (instr_class),
        .illegal     (dec_illegal)
    );

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH:    if (mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_next = ST_ERROR;
                end else begin
                    case (instr_class)
                        CLS_LOAD, CLS_STORE: state_next = ST_MEMADR;
                        CLS_RTYPE:           state_next = ST_EXECR;
                        CLS_ITYPE:           state_next = ST_EXECI;
                        CLS_BEQ:             state_next = ST_BEQ;
                        CLS_JAL:             state_next = ST_JAL;
                        CLS_LUI:             state_next = ST_LUI;
                        default:             state_next = ST_ERROR;
                    endcase
                end
            end
            ST_MEMADR:   state_next = (instr_class == CLS_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  if (mem_ready) state_next = ST_MEMWB;
            ST_MEMWB:    state_next = ST_FETCH;
            ST_MEMWRITE: if (mem_ready) state_next = ST_FETCH;
            ST_EXECR:    state_next = ST_ALUWB;
            ST_EXECI:    state_next = ST_ALUWB;
            ST_ALUWB:    state_next = ST_FETCH;
            ST_BEQ:      state_next = ST_FETCH;
            ST_JAL:      state_next = ST_ALUWB;
            ST_LUI:      state_next = ST_ALUWB;
            ST_ERROR:    state_next = ST_ERROR;
            // Unused encodings are treated as a fault and parked in ERROR.
            default:     state_next = ST_ERROR;
        endcase
    end

    // Final cycle of an instruction: this is when it counts as retired.
    assign retire_now = (state_reg == ST_ALUWB) ||
                        (state_reg == ST_MEMWB) ||
                        (state_reg == ST_BEQ)   ||
                        ((state_reg == ST_MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_FETCH;
            retired_reg <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (retire_now) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
            // ERROR is absorbing, so setting on entry makes the flag sticky.
            if (state_next == ST_ERROR) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    // Moore output decode from the registered state. pc_write/ir_write in
    // FETCH and pc_write in BEQ additionally follow mem_ready / zero.
    always_comb begin
        alu_op     = ALUOP_ADD;
        func_code  = {funct7, funct3};
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        adr_src    = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            ST_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMREAD: begin
                adr_src = 1'b1;
            end
            ST_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_RTYPE;
            end
            ST_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ITYPE;
                // funct7 carries immediate bits for I-type, so it is masked.
                func_code = {7'b0, funct3};
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_RTYPE;
                func_code = FUNC_SUB;
                pc_write  = zero;
            end
            ST_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            ST_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            ST_ERROR: begin
                alu_op = ALUOP_ERR;
            end
            default: begin
                alu_op = ALUOP_ADD;
            end
        endcase
        // No architectural write may happen in a reset cycle.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign illegal = illegal_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl. The driver walks each instruction
// through the cycle sequence implied by its class, pushing the expected
// output vector for every cycle into a queue; a negedge monitor pops and
// compares against the DUT outputs.
module tb_riscv_mc_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             zero;
    logic             mem_ready;
    logic [1:0]       alu_op;
    logic [9:0]       func_code;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       result_src;
    logic             adr_src;
    logic             pc_write;
    logic             ir_write;
    logic             mem_write;
    logic             reg_write;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    riscv_mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .func_code  (func_code),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       alu_op;
        logic [9:0]       func_code;
        logic [1:0]       src_a;
        logic [1:0]       src_b;
        logic [1:0]       result_src;
        logic             adr_src;
        logic             pc_write;
        logic             ir_write;
        logic             mem_write;
        logic             reg_write;
        logic             illegal;
        logic [CNT_W-1:0] retired;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cycle_no = 0;

    // Reference state: instructions retired since reset and the sticky flag.
    int    retired_model = 0;
    bit    ill_model = 1'b0;
    exp_t  e;

    // ---------------- monitor ----------------
    exp_t  mon_exp;
    exp_t  mon_act;
    string mon_tag;

    always @(negedge clk) begin
        cycle_no++;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {alu_op, func_code, alu_src_a, alu_src_b, result_src, adr_src,
                       pc_write, ir_write, mem_write, reg_write, illegal, retired};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h required %h (alu_op %b/%b func %0d/%0d srcA %b/%b srcB %b/%b res %b/%b adr %b/%b pcw %b/%b irw %b/%b mw %b/%b rw %b/%b ill %b/%b ret %0d/%0d)",
                         mon_tag, cycle_no, mon_act, mon_exp,
                         mon_act.alu_op, mon_exp.alu_op, mon_act.func_code, mon_exp.func_code,
                         mon_act.src_a, mon_exp.src_a, mon_act.src_b, mon_exp.src_b,
                         mon_act.result_src, mon_exp.result_src, mon_act.adr_src, mon_exp.adr_src,
                         mon_act.pc_write, mon_exp.pc_write, mon_act.ir_write, mon_exp.ir_write,
                         mon_act.mem_write, mon_exp.mem_write, mon_act.reg_write, mon_exp.reg_write,
                         mon_act.illegal, mon_exp.illegal, mon_act.retired, mon_exp.retired);
            end
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic exp_t blank();
        exp_t r;
        r = '0;
        r.func_code = {funct7, funct3};
        r.retired   = CNT_W'(retired_model % (1 << CNT_W));
        r.illegal   = ill_model;
        return r;
    endfunction

    task automatic cyc(input exp_t r, input string tag, input bit fin);
        exp_q.push_back(r);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (fin) retired_model = retired_model + 1;
    endtask

    task automatic rnd_misc();
        mem_ready = 1'($urandom);
        zero      = 1'($urandom);
    endtask

    task automatic aluwb();
        rnd_misc();
        e = blank();
        e.reg_write = 1'b1;
        cyc(e, "ALUWB", 1'b1);
    endtask

    function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3);
        if (op == 7'b1100011) return (f3 == 3'b000);
        return (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
               (op == 7'b0010011) || (op == 7'b1101111) || (op == 7'b0110111);
    endfunction

    // Issue one instruction. fstall/mstall: cycles of mem_ready low in FETCH
    // and in the memory state. rst_at: store stall index at which reset is
    // asserted (-1 for none).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int fstall, input int mstall, input bit z, input int rst_at);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        $display("instr op=%b f3=%b f7=%b fstall=%0d mstall=%0d zero=%0d retired_before=%0d",
                 op, f3, f7, fstall, mstall, z, retired_model % (1 << CNT_W));
        for (int i = 0; i <= fstall; i++) begin
            zero = 1'($urandom);
            mem_ready = (i == fstall);
            e = blank();
            e.src_b = 2'b10; e.result_src = 2'b10;
            e.ir_write = mem_ready; e.pc_write = mem_ready;
            cyc(e, "FETCH", 1'b0);
        end
        rnd_misc();
        e = blank();
        e.src_a = 2'b01; e.src_b = 2'b01;
        cyc(e, "DECODE", 1'b0);
        if (!is_legal(op, f3)) begin
            ill_model = 1'b1;
            for (int k = 0; k < 3; k++) begin
                rnd_misc();
                e = blank();
                e.alu_op = 2'b11;
                cyc(e, "ERROR", 1'b0);
            end
            reset = 1'b1;
            rnd_misc();
            e = blank();
            e.alu_op = 2'b11;
            cyc(e, "RST_ERROR", 1'b0);
            reset = 1'b0;
            retired_model = 0;
            ill_model = 1'b0;
        end else if (op == 7'b0000011 || op == 7'b0100011) begin
            rnd_misc();
            e = blank();
            e.src_a = 2'b10; e.src_b = 2'b01;
            cyc(e, "MEMADR", 1'b0);
            for (int i = 0; i <= mstall; i++) begin
                zero = 1'($urandom);
                mem_ready = (i == mstall);
                e = blank();
                e.adr_src = 1'b1;
                if (op == 7'b0000011) begin
                    cyc(e, "MEMREAD", 1'b0);
                end else if (i == rst_at) begin
                    reset = 1'b1;
                    mem_ready = 1'($urandom);
                    cyc(e, "RST_MEMWRITE", 1'b0);
                    reset = 1'b0;
                    retired_model = 0;
                    ill_model = 1'b0;
                    return;
                end else begin
                    e.mem_write = 1'b1;
                    cyc(e, "MEMWRITE", (i == mstall));
                end
            end
            if (op == 7'b0000011) begin
                rnd_misc();
                e = blank();
                e.result_src = 2'b01; e.reg_write = 1'b1;
                cyc(e, "MEMWB", 1'b1);
            end
        end else if (op == 7'b0110011) begin
            rnd_misc();
            e = blank();
            e.src_a = 2'b10; e.alu_op = 2'b10;
            cyc(e, "EXECR", 1'b0);
            aluwb();
        end else if (op == 7'b0010011) begin
            rnd_misc();
            e = blank();
            e.src_a = 2'b10; e.src_b = 2'b01; e.alu_op = 2'b01;
            e.func_code = 10'(f3);
            cyc(e, "EXECI", 1'b0);
            aluwb();
        end else if (op == 7'b1100011) begin
            mem_ready = 1'($urandom);
            zero = z;
            e = blank();
            e.src_a = 2'b10; e.alu_op = 2'b10; e.func_code = 10'd256;
            e.pc_write = z;
            cyc(e, "BEQ", 1'b1);
        end else if (op == 7'b1101111) begin
            rnd_misc();
            e = blank();
            e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1'b1;
            cyc(e, "JAL", 1'b0);
            aluwb();
        end else begin
            rnd_misc();
            e = blank();
            e.src_a = 2'b11; e.src_b = 2'b01;
            cyc(e, "LUI", 1'b0);
            aluwb();
        end
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] legal_ops [7];
    logic [6:0] rop;
    logic [2:0] rf3;

    initial begin
        legal_ops[0] = 7'b0000011; legal_ops[1] = 7'b0100011; legal_ops[2] = 7'b0110011;
        legal_ops[3] = 7'b0010011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b1101111;
        legal_ops[6] = 7'b0110111;

        reset = 1'b1;
        opcode = '0; funct3 = '0; funct7 = '0;
        rnd_misc();
        @(posedge clk);
        #1;
        // Reset still held: FETCH outputs with every enable forced low.
        mem_ready = 1'b1;
        e = blank();
        e.src_b = 2'b10; e.result_src = 2'b10;
        cyc(e, "RST_HOLD", 1'b0);
        reset = 1'b0;

        // Directed cases
        run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0, 1'b0, -1);  // R-type SUB
        run_instr(7'b0000011, 3'b010, 7'h15, 0, 2, 1'b0, -1);       // load, 2 stalls
        run_instr(7'b1100011, 3'b000, 7'h00, 0, 0, 1'b1, -1);       // BEQ taken
        run_instr(7'b1100011, 3'b000, 7'h00, 0, 0, 1'b0, -1);       // BEQ not taken
        run_instr(7'b1111111, 3'b000, 7'h00, 0, 0, 1'b0, -1);       // illegal + reset
        run_instr(7'b0110011, 3'b111, 7'h00, 0, 0, 1'b0, -1);       // bump count
        run_instr(7'b0100011, 3'b010, 7'h00, 0, 3, 1'b0, 1);        // store, reset in stall
        for (int n = 0; n < 16; n++) begin
            run_instr(7'b0010011, 3'b000, 7'($urandom), 0, 0, 1'b0, -1);  // ADDI wrap
        end

        // Randomized stream
        for (int n = 0; n < 200; n++) begin
            rf3 = 3'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                rop = 7'($urandom);
            end else begin
                rop = legal_ops[$urandom_range(0, 6)];
                if (rop == 7'b1100011 && $urandom_range(0, 3) != 0) rf3 = 3'b000;
            end
            run_instr(rop, rf3, 7'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom), -1);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion required completion within budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multicycle main control FSM for the RISC-V datapath. It fetches and decodes each instruction, then steps it through execute, memory and writeback states. It drives the ALU control decoder's ALUOp/FuncCode inputs and all datapath mux selects and write enables. It sits between the instruction register/memory interface and the existing ALU control decoder, and also counts retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- alu_op  out  2  to ALU decoder: 00 add, 01 I-type, 10 R-type, 11 error
- func_code  out  10  to ALU decoder FuncCode
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 (A reg), 11 zero
- alu_src_b  out  2  00 rs2 (B reg), 01 imm, 10 constant 4
- result_src  out  2  00 ALUOut reg, 01 memory data reg, 10 ALU result direct
- adr_src  out  1  memory address: 0 PC, 1 result
- pc_write, ir_write, mem_write, reg_write  out  1 each  write enables
- illegal  out  1  sticky illegal-instruction flag
- retired  out  CNT_W  retired-instruction count

## Operation
- Moore FSM. Outputs decode from the registered state; pc_write in BEQ also depends on zero, and ir_write/pc_write in FETCH also depend on mem_ready.
- Unlisted outputs in each state are 0.
- Default func_code = {funct7, funct3}.
- FETCH: adr_src 0, srcA 00, srcB 10, alu_op 00, result_src 10, ir_write = pc_write = mem_ready. Stay while !mem_ready, else go to DECODE.
- DECODE: srcA 01, srcB 01, alu_op 00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 with funct3 000 → BEQ
  - 1101111 → JAL
  - 0110111 → LUI
  - anything else → ERROR
- MEMADR: srcA 10, srcB 01, alu_op 00. Load → MEMREAD; store → MEMWRITE.
- MEMREAD: adr_src 1, result_src 00. Hold until mem_ready, then MEMWB.
- MEMWB: result_src 01, reg_write 1 → FETCH.
- MEMWRITE: adr_src 1, result_src 00, mem_write 1, held until mem_ready → FETCH.
- EXECR: srcA 10, srcB 00, alu_op 10 → ALUWB.
- EXECI: srcA 10, srcB 01, alu_op 01, func_code = {7'b0, funct3} → ALUWB.
- ALUWB: result_src 00, reg_write 1 → FETCH.
- BEQ: srcA 10, srcB 00, alu_op 10, func_code 10'b0100000000 (subtract), result_src 00, pc_write = zero → FETCH.
- JAL: srcA 01, srcB 10, alu_op 00, result_src 00, pc_write 1 → ALUWB.
- LUI: srcA 11, srcB 01, alu_op 00 → ALUWB.
- ERROR: all enables 0, alu_op 11, illegal 1. Absorbing until reset.
- retired increments by 1 on the final cycle of each instruction: ALUWB, MEMWB, MEMWRITE with mem_ready, and BEQ. It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (edge sampled, reset high):
  - state ← FETCH, retired ← 0, illegal ← 0.
  - While reset is high, pc_write, ir_write, mem_write and reg_write are forced 0 regardless of state.
- Reset mid-instruction aborts it; no write occurs in the reset cycle, and FETCH begins on the first cycle after reset deasserts.
- Latency with mem_ready=1 (cycles FETCH→FETCH):
  - BEQ: 3
  - R-type, I-type, store, JAL, LUI: 4
  - load: 5
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- opcode/funct are sampled in DECODE and later states. The IR is stable after FETCH because ir_write is 0 elsewhere.
- Counter wrap and ERROR entry in the same instruction cannot coincide. ERROR never increments retired.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - opcode constants
  - ALUOp encodings (ADD/ITYPE/RTYPE/ERR)
  - FUNC_SUB = 10'b0100000000
  - srcA/srcB/result_src encodings
  - state enum (13 states)
- Sub-module riscv_opcode_dec is natural. It is purely combinational: opcode+funct3 → instruction class + illegal, and feeds the DECODE transition.
- The ALU control decoder is instantiated at datapath level, not inside this block.

## Test plan
- Reset, then R-type (opcode 0110011, funct7 0100000, funct3 000), mem_ready=1 → EXECR alu_op=10, func_code=256; reg_write pulses in cycle 4; retired=1.
- Load with mem_ready low 2 cycles in MEMREAD → adr_src=1 held; reg_write in cycle 7; retired increments once.
- BEQ with zero=1, then zero=0 → pc_write=1 in cycle 3 only when zero=1; func_code=256 in both; retired +1 each.
- Opcode 1111111 → ERROR after DECODE, illegal=1, alu_op=11, no enables thereafter; reset → FETCH, illegal=0.
- Store with mem_ready stalled 3 cycles in MEMWRITE, reset asserted in the second stall cycle → mem_write=0 in the reset cycle, FETCH next, retired=0.
- CNT_W=4, 16 ADDIs (opcode 0010011, funct3 000) → func_code=0 in EXECI; retired wraps 15→0.
